// File: rtl/decoder_pkg.sv
// decoder_pkg: framing states and constants shared by the
// PCM frame decoder and its bit synchroniser.
package decoder_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCK   = 2'd2
  } frame_state_t;

  localparam logic [15:0] SYNC_DEFAULT  = 16'hEB90;
  localparam int          BITS_PER_WORD = 8;

endpackage

// File: rtl/decoder_bit_sync.sv
// decoder_bit_sync: PCM synchroniser, transition detect and
// free-running phase counter producing one strobe per bit.
module decoder_bit_sync #(
  parameter int CLK_PER_BIT = 8
) (
  input  logic CLOCK_BMQ,
  input  logic RESET_N,
  input  logic PCM,
  output logic Bit_Data,
  output logic Bit_Strobe
);

  localparam int PW = $clog2(CLK_PER_BIT);
  localparam logic [PW-1:0] SAMPLE_PH = PW'(CLK_PER_BIT / 2 - 1);
  localparam logic [PW-1:0] LAST_PH   = PW'(CLK_PER_BIT - 1);

  logic [2:0]    sync_q;
  logic [PW-1:0] phase_q;
  logic          edge_seen;

  assign edge_seen = sync_q[2] ^ sync_q[1];

  // A transition realigns the phase and wins over a due sample.
  always_ff @(posedge CLOCK_BMQ) begin
    if (!RESET_N) begin
      sync_q     <= '0;
      phase_q    <= '0;
      Bit_Data   <= 1'b0;
      Bit_Strobe <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], PCM};
      Bit_Strobe <= 1'b0;
      if (edge_seen) begin
        phase_q <= '0;
      end else begin
        phase_q <= (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
        if (phase_q == SAMPLE_PH) begin
          Bit_Strobe <= 1'b1;
          Bit_Data   <= sync_q[2];
        end
      end
    end
  end

endmodule

// File: rtl/decoder_pcm_frame.sv
// decoder_pcm_frame: sync search/verify/lock framing and
// word de-serialisation of the serial PCM telemetry stream.
module decoder_pcm_frame
  import decoder_pkg::*;
#(
  parameter int          CLK_PER_BIT     = 8,
  parameter int          WORDS_PER_FRAME = 128,
  parameter logic [15:0] SYNC_WORD       = SYNC_DEFAULT,
  parameter int          VERIFY_FRAMES   = 2,
  parameter int          MISS_LIMIT      = 3
) (
  input  logic        CLOCK_BMQ,
  input  logic        RESET_N,
  input  logic        PCM,
  output logic [7:0]  Data_Word,
  output logic [6:0]  ID_Channel,
  output logic        Word_Valid,
  output logic        Frame_Start,
  output logic        Locked,
  output logic [15:0] Counter_Frame
);

  localparam int FRAME_BITS = WORDS_PER_FRAME * BITS_PER_WORD;
  localparam int CW = $clog2(FRAME_BITS);
  localparam int VW = $clog2(VERIFY_FRAMES + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [CW-1:0] SYNC_END = CW'(16);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

  frame_state_t  state_q, state_d;
  logic [15:0]   shift_q, shift_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [CW-4:0] word_idx;
  logic [VW-1:0] verify_q, verify_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          bit_data, bit_strobe;
  logic          sync_hit, at_sync, word_done, emit;

  decoder_bit_sync #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_bit_sync (
    .CLOCK_BMQ (CLOCK_BMQ),
    .RESET_N   (RESET_N),
    .PCM       (PCM),
    .Bit_Data  (bit_data),
    .Bit_Strobe(bit_strobe)
  );

  assign shift_d     = {shift_q[14:0], bit_data};
  assign sync_hit    = (shift_d == SYNC_WORD);
  assign bit_cnt_inc = (bit_cnt_q == LAST_BIT) ? '0
                                               : bit_cnt_q + 1'b1;
  assign at_sync     = (bit_cnt_inc == SYNC_END);
  assign word_done   = (bit_cnt_inc[2:0] == 3'd0);
  assign word_idx    = bit_cnt_q[CW-1:3];
  assign Locked      = (state_q == LOCK);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    verify_d  = verify_q;
    miss_d    = miss_q;
    emit      = 1'b0;
    if (bit_strobe) begin
      bit_cnt_d = bit_cnt_inc;
      unique case (state_q)
        SEARCH: begin
          if (sync_hit) begin
            state_d   = CHECK;
            bit_cnt_d = SYNC_END;
            verify_d  = '0;
          end
        end
        CHECK: begin
          if (at_sync) begin
            if (!sync_hit) begin
              state_d = SEARCH;
            end else if (verify_q == VW'(VERIFY_FRAMES - 1)) begin
              state_d = LOCK;
              miss_d  = '0;
            end else begin
              verify_d = verify_q + 1'b1;
            end
          end
        end
        LOCK: begin
          emit = word_done;
          // Flywheel: isolated misses keep the frame timing.
          if (at_sync) begin
            if (sync_hit) begin
              miss_d = '0;
            end else if (miss_q == MW'(MISS_LIMIT - 1)) begin
              state_d = SEARCH;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge CLOCK_BMQ) begin
    if (!RESET_N) begin
      state_q       <= SEARCH;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      verify_q      <= '0;
      miss_q        <= '0;
      Data_Word     <= '0;
      ID_Channel    <= '0;
      Word_Valid    <= 1'b0;
      Frame_Start   <= 1'b0;
      Counter_Frame <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      verify_q    <= verify_d;
      miss_q      <= miss_d;
      Word_Valid  <= emit;
      Frame_Start <= emit && (word_idx == '0);
      if (bit_strobe) begin
        shift_q <= shift_d;
      end
      if (emit) begin
        Data_Word  <= shift_d[7:0];
        ID_Channel <= 7'(word_idx);
      end
      if (emit && (word_idx == '0)) begin
        Counter_Frame <= Counter_Frame + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_decoder_pcm_frame.sv
// tb_decoder_pcm_frame: random and scripted PCM streams checked
// word by word against a frame-level reference model.
module tb_decoder_pcm_frame;

  localparam int          CPB  = 8;
  localparam int          W    = 16;
  localparam int          F    = W * 8;
  localparam int          VER  = 2;
  localparam int          MISS = 3;
  localparam logic [15:0] SYNC = 16'hEB90;

  typedef struct packed {
    logic [7:0]  d;
    logic [6:0]  ch;
    logic        fs;
    logic        lk;
    logic        first;
    logic [15:0] cf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcm = 1'b0;
  logic [7:0]  data_word;
  logic [6:0]  id_ch;
  logic        wv, fs, locked;
  logic [15:0] cf;

  always #5 clk = ~clk;

  decoder_pcm_frame #(
    .CLK_PER_BIT    (CPB),
    .WORDS_PER_FRAME(W),
    .SYNC_WORD      (SYNC),
    .VERIFY_FRAMES  (VER),
    .MISS_LIMIT     (MISS)
  ) dut (
    .CLOCK_BMQ    (clk),
    .RESET_N      (rst_n),
    .PCM          (pcm),
    .Data_Word    (data_word),
    .ID_Channel   (id_ch),
    .Word_Valid   (wv),
    .Frame_Start  (fs),
    .Locked       (locked),
    .Counter_Frame(cf)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  longint last_wv = 0;
  bit     checking = 1'b0;
  bit     gap_on = 1'b0;
  int     bit_idx = -1;
  bit     bits[$];
  exp_t   expq[$];
  exp_t   cur;
  logic [15:0] model_cf = '0;
  bit     model_lk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] win(int i);
    logic [15:0] w = '0;
    for (int b = 0; b < 16; b++) w = {w[14:0], bits[i-15+b]};
    return w;
  endfunction

  // Frame-level reading of the stream: find a sync, confirm it
  // VER more frames on, then cut every byte until MISS misses.
  task automatic build_model();
    int   n, i, j, p, k, e, misses;
    bit   ok;
    exp_t x;
    n = bits.size();
    i = 15;
    model_lk = 1'b0;
    while (i < n) begin
      if (win(i) != SYNC) begin
        i++;
        continue;
      end
      ok = 1'b1;
      for (int v = 1; v <= VER; v++) begin
        j = i + v * F;
        if (j >= n) begin
          i = n; ok = 1'b0; break;
        end
        if (win(j) != SYNC) begin
          i = j + 1; ok = 1'b0; break;
        end
      end
      if (!ok) continue;
      p = i + VER * F;
      i = n;
      misses = 0;
      model_lk = 1'b1;
      k = 1;
      while (p + 8 * k < n) begin
        e = p + 8 * k;
        x.d = win(e)[7:0];
        x.ch = 7'((k + 1) % W);
        x.fs = (x.ch == 0);
        x.first = (k == 1);
        x.lk = 1'b1;
        if ((8 * k) % F == 0) begin
          if (win(e) == SYNC) misses = 0;
          else misses++;
          if (misses == MISS) begin
            x.lk = 1'b0; model_lk = 1'b0; i = e + 1;
          end
        end
        if (x.fs) model_cf = model_cf + 16'd1;
        x.cf = model_cf;
        expq.push_back(x);
        if (!x.lk) break;
        k++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (checking && wv) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_word: got ch %0d data %0h expected none",
                 id_ch, data_word);
      end else begin
        cur = expq.pop_front();
        chk("data", 32'(data_word), 32'(cur.d));
        chk("channel", 32'(id_ch), 32'(cur.ch));
        chk("frame_start", 32'(fs), 32'(cur.fs));
        chk("locked", 32'(locked), 32'(cur.lk));
        chk("counter_frame", 32'(cf), 32'(cur.cf));
        if (gap_on && !cur.first)
          chk("wv_spacing", 32'(cyc - last_wv), 32'(64));
      end
      last_wv = cyc;
    end
  end

  task automatic push_byte(logic [7:0] v);
    for (int i = 7; i >= 0; i--) bits.push_back(v[i]);
  endtask

  task automatic push_frame(logic [7:0] w0, logic [7:0] w1, bit rnd);
    push_byte(w0);
    push_byte(w1);
    for (int c = 2; c < W; c++)
      push_byte(rnd ? 8'($urandom) : 8'(c));
  endtask

  task automatic send(bit jit);
    for (int b = 0; b < bits.size(); b++) begin
      pcm = bits[b];
      bit_idx = b;
      repeat (jit ? ((b % 2) ? 9 : 7) : CPB) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    checking = 1'b0;
    pcm = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_data", 32'(data_word), 0);
    chk("rst_channel", 32'(id_ch), 0);
    chk("rst_valid", 32'(wv), 0);
    chk("rst_frame_start", 32'(fs), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_counter", 32'(cf), 0);
    rst_n = 1'b1;
    model_cf = '0;
    bit_idx = -1;
    bits.delete();
    expq.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic run(bit jit, bit gap);
    gap_on = gap;
    checking = 1'b1;
    send(jit);
    repeat (2) @(negedge clk);
    chk("missing_words", 32'(expq.size()), 0);
    chk("end_locked", 32'(locked), 32'(model_lk));
    chk("end_counter", 32'(cf), 32'(model_cf));
    checking = 1'b0;
  endtask

  initial begin
    do_reset();

    for (int f = 0; f < 6; f++) push_frame(8'hEB, 8'h90, 1'b0);
    build_model();
    chk("model_s1_words", 32'(expq.size()), 62);
    chk("model_s1_first_ch", 32'(expq[0].ch), 2);
    chk("model_s1_ch5_data", 32'(expq[3].d), 5);
    chk("model_s1_frames", 32'(model_cf), 3);
    fork
      begin
        wait (bit_idx == 15 + 2 * F);
        @(negedge clk);
        chk("lock_early", 32'(locked), 0);
        wait (bit_idx == 16 + 2 * F);
        @(negedge clk);
        chk("lock_rise", 32'(locked), 1);
      end
    join_none
    run(1'b0, 1'b1);
    chk("s1_counter", 32'(cf), 3);

    do_reset();
    for (int i = 0; i < 300; i++) bits.push_back(1'($urandom));
    for (int f = 0; f < 6; f++) push_frame(8'hEB, 8'h90, 1'b0);
    build_model();
    run(1'b0, 1'b1);

    do_reset();
    for (int f = 0; f < 14; f++)
      push_frame((f inside {4, 5, 9, 10, 11}) ? 8'h00 : 8'hEB,
                 8'h90, 1'b0);
    build_model();
    chk("model_s3_frames", 32'(model_cf), 9);
    run(1'b0, 1'b1);
    chk("s3_counter_hold", 32'(cf), 9);
    chk("s3_unlocked", 32'(locked), 0);

    do_reset();
    for (int f = 0; f < 6; f++)
      push_frame(8'hEB, (f == 1) ? 8'h91 : 8'h90, 1'b0);
    build_model();
    chk("model_s4_words", 32'(expq.size()), 30);
    run(1'b0, 1'b1);
    chk("s4_counter", 32'(cf), 1);

    do_reset();
    for (int f = 0; f < 11; f++) push_frame(8'hEB, 8'h90, 1'b1);
    build_model();
    run(1'b1, 1'b0);

    do_reset();
    for (int f = 0; f < 4; f++) push_frame(8'hEB, 8'h90, 1'b0);
    push_byte(8'hEB);
    push_byte(8'h90);
    push_byte(8'h02);
    build_model();
    run(1'b0, 1'b1);
    chk("s6_locked_before_reset", 32'(locked), 1);
    do_reset();
    for (int f = 0; f < 4; f++) push_frame(8'hEB, 8'h90, 1'b0);
    build_model();
    run(1'b0, 1'b1);
    chk("s6_relocked", 32'(locked), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_pcm_frame.md
# decoder_pcm_frame

Receive-side counterpart of the PCM telemetry encoder. Recovers bit timing from the serial NRZ PCM line, searches for and verifies the frame sync pattern, and de-serialises each frame into 8-bit channel words tagged with channel number and frame count. Sits at the ground/test-equipment end of the link, clocked from the same 4 MHz domain as the encoder.

## Interface
Parameters:
- CLK_PER_BIT, 8: CLOCK_BMQ cycles per PCM bit (even, ≥4).
- WORDS_PER_FRAME, 128: 8-bit words per frame, including the two sync words.
- SYNC_WORD, 16'hEB90: frame sync pattern, carried MSB-first in words 0 and 1.
- VERIFY_FRAMES, 2: consecutive correct syncs required in CHECK before LOCK.
- MISS_LIMIT, 3: consecutive sync misses in LOCK before returning to SEARCH.

Ports:
- CLOCK_BMQ  in  1  4 MHz system clock; all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- PCM  in  1  serial NRZ PCM, asynchronous to CLOCK_BMQ, MSB first.
- Data_Word  out  8  decoded word; valid while Word_Valid is high.
- ID_Channel  out  7  channel index of Data_Word, 0..WORDS_PER_FRAME-1.
- Word_Valid  out  1  one-cycle strobe per decoded word.
- Frame_Start  out  1  one-cycle strobe coincident with Word_Valid for channel 0.
- Locked  out  1  high while the state machine is in LOCK.
- Counter_Frame  out  16  count of frames decoded while locked.

## Operation
- Input conditioning: PCM passes through a 2-FF synchroniser; edge = XOR of last two synchronised samples.
- Bit timing: phase counter 0..CLK_PER_BIT-1, free-running, wraps to 0. Edge detected: phase ← 0. Sample taken when phase == CLK_PER_BIT/2-1 with no edge that cycle; the edge has priority and suppresses the sample. Each sample shifts into a 16-bit shift register (LSB in).
- States: SEARCH, CHECK, LOCK.
- SEARCH: after every sample compare shift register with SYNC_WORD. Match → CHECK, bit counter ← 16, verify count ← 0.
- CHECK: bit counter counts samples modulo WORDS_PER_FRAME×8. At wrap to 16 compare again: match → verify count +1; reaching VERIFY_FRAMES → LOCK, miss count ← 0. Any mismatch → SEARCH. No words output.
- LOCK: every 8th sample emits Data_Word = low 8 bits of shift register, ID_Channel = bit counter/8 of the completed word (wraps WORDS_PER_FRAME-1 → 0). Sync words 0 and 1 are emitted as ordinary channels. At each sync point: match → miss count ← 0; mismatch → miss count +1; reaching MISS_LIMIT → SEARCH. Frame boundaries are flywheeled through misses below the limit; words still emitted.
- Counter_Frame: +1 on every Frame_Start; wraps 16'hFFFF → 0; holds when not locked; not cleared on loss of lock.
- Reset mid-frame: everything returns to reset values on the next edge; a partial frame is discarded.

## Timing
- Reset values: Data_Word 0, ID_Channel 0, Word_Valid 0, Frame_Start 0, Locked 0, Counter_Frame 0; state SEARCH, phase, shift register and all counters 0.
- Sample point: CLK_PER_BIT/2+2 cycles after a PCM transition (2 synchroniser, 1 edge register, CLK_PER_BIT/2-1 count).
- Word_Valid, Data_Word, ID_Channel, Frame_Start registered; asserted the cycle after the sample of the word's last bit (LSB).
- Locked rises the cycle after the final verifying sync compare; falls the cycle after the MISS_LIMIT-th miss compare.
- Frame_Start appears only on the channel-0 word; Counter_Frame updates in the same cycle as Frame_Start.
- Word_Valid spacing in LOCK: exactly 8×CLK_PER_BIT cycles for a clean input.

## Structure
- Shared package decoder_pkg: state encoding (SEARCH/CHECK/LOCK), default SYNC_WORD, bits-per-word constant 8.
- Sub-module decoder_bit_sync: synchroniser, edge detect, phase counter; outputs Bit_Data and a one-cycle Bit_Strobe. Framing FSM and word output stay in decoder_pcm_frame.

## Test plan
- Clean stream, defaults, frames with words 0/1 = EB/90 and channel n = n: Locked rises at end of the 3rd sync (1 found + 2 verified); thereafter Word_Valid every 64 cycles, channel 5 → Data_Word 8'h05, Counter_Frame increments per frame.
- Random 300 bits then clean frames: no Word_Valid before Locked; first Frame_Start is the first channel 0 after lock.
- Locked, corrupt sync in 2 consecutive frames: Locked stays high, words still emitted; corrupt 3 consecutive: Locked drops after the 3rd compare, Counter_Frame holds.
- CHECK with the second sync wrong: returns to SEARCH, no Word_Valid, relocks on next valid sequence.
- Transmitter at CLK_PER_BIT±1 cycles per bit on alternate bits (±12% jitter): zero data errors over 10 frames.
- RESET_N low for one cycle mid-frame while locked: all outputs at reset values next cycle; relock from SEARCH.
